// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the parameterised combination lock.
package combo_lock_pkg;

    // Top-level lock modes.
    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROG     = 2'd2,
        ST_LOCKOUT  = 2'd3
    } lockState_t;

    // Factory code loaded at reset; digit 0 is the most significant nibble.
    localparam logic [15:0] DEFAULT_CODE_VAL = 16'hFACE;

endpackage

// File: rtl/combo_lockout_timer.sv
// Lockout down-counter.
// Ports: clk, rst_n (async, active-low); load restarts the count at CYCLES;
// count decrements while nonzero; done is high during the final lockout cycle.
module combo_lockout_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] remaining;

    // done is registered one cycle ahead so it coincides with remaining == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            done      <= 1'b0;
        end else if (load) begin
            remaining <= CNT_W'(CYCLES);
            done      <= (CYCLES == 1);
        end else if (count && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
            done      <= (remaining == CNT_W'(2));
        end
    end

endmodule

// File: rtl/param_combo_lock.sv
// Parameterised digital combination lock with programmable code and lockout.
// Ports: clk, rst_n (async, active-low); btn_inc/btn_dec move the dial;
// btn_enter commits the dial digit; btn_prog enters/aborts program mode.
// Outputs (all registered): cur_digit, digit_idx, unlocked, prog_active,
// alarm, bad_code (one-cycle pulse), fail_cnt.
module param_combo_lock
    import combo_lock_pkg::*;
#(
    parameter  int unsigned CODE_LEN       = 4,
    parameter  int unsigned DIGIT_W        = 4,
    parameter  int unsigned MAX_TRIES      = 3,
    parameter  int unsigned LOCKOUT_CYCLES = 16,
    localparam int unsigned CODE_W         = CODE_LEN * DIGIT_W,
    localparam int unsigned IDX_W          = $clog2(CODE_LEN + 1),
    localparam int unsigned FAIL_W         = $clog2(MAX_TRIES + 1),
    parameter  logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(DEFAULT_CODE_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_enter,
    input  logic              btn_prog,
    output logic [DIGIT_W-1:0] cur_digit,
    output logic [IDX_W-1:0]  digit_idx,
    output logic              unlocked,
    output logic              prog_active,
    output logic              alarm,
    output logic              bad_code,
    output logic [FAIL_W-1:0] fail_cnt
);

    lockState_t         state, stateNxt;
    logic [DIGIT_W-1:0] dialNxt, dialStep, expDigit;
    logic [IDX_W-1:0]   idxNxt;
    logic [FAIL_W-1:0]  failNxt, failInc;
    logic [CODE_W-1:0]  code, codeNxt, shadow, shadowNxt, shadowShifted, codeShifted;
    logic               errFlag, errNxt, badNxt;
    logic               mismatch, lastDigit;
    logic               timerLoad, timerDone;

    combo_lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) uTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timerLoad),
        .count (state == ST_LOCKOUT),
        .done  (timerDone)
    );

    // Dial movement; simultaneous inc and dec cancel out.
    always_comb begin
        dialStep = cur_digit;
        if (btn_inc && !btn_dec) begin
            dialStep = cur_digit + DIGIT_W'(1);
        end else if (btn_dec && !btn_inc) begin
            dialStep = cur_digit - DIGIT_W'(1);
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        stateNxt  = state;
        dialNxt   = cur_digit;
        idxNxt    = digit_idx;
        failNxt   = fail_cnt;
        codeNxt   = code;
        shadowNxt = shadow;
        errNxt    = errFlag;
        badNxt    = 1'b0;
        timerLoad = 1'b0;

        codeShifted   = code << (32'(digit_idx) * DIGIT_W);
        expDigit      = codeShifted[CODE_W-1 -: DIGIT_W];
        mismatch      = (cur_digit != expDigit);
        lastDigit     = (digit_idx == IDX_W'(CODE_LEN - 1));
        shadowShifted = {shadow[CODE_W-DIGIT_W-1:0], cur_digit};
        failInc       = fail_cnt + FAIL_W'(1);

        case (state)
            ST_ENTRY: begin
                if (btn_enter) begin
                    if (lastDigit) begin
                        idxNxt = '0;
                        errNxt = 1'b0;
                        if (errFlag || mismatch) begin
                            badNxt  = 1'b1;
                            failNxt = failInc;
                            if (failInc == FAIL_W'(MAX_TRIES)) begin
                                stateNxt  = ST_LOCKOUT;
                                timerLoad = 1'b1;
                            end
                        end else begin
                            stateNxt = ST_UNLOCKED;
                            failNxt  = '0;
                        end
                    end else begin
                        idxNxt = digit_idx + IDX_W'(1);
                        errNxt = errFlag | mismatch;
                    end
                end else begin
                    dialNxt = dialStep;
                end
            end
            ST_UNLOCKED: begin
                if (btn_enter) begin
                    stateNxt = ST_ENTRY;
                    idxNxt   = '0;
                    errNxt   = 1'b0;
                end else if (btn_prog) begin
                    stateNxt  = ST_PROG;
                    idxNxt    = '0;
                    shadowNxt = '0;
                end
            end
            ST_PROG: begin
                if (btn_prog) begin
                    stateNxt = ST_UNLOCKED;
                    idxNxt   = '0;
                end else if (btn_enter) begin
                    if (lastDigit) begin
                        codeNxt  = shadowShifted;
                        stateNxt = ST_ENTRY;
                        idxNxt   = '0;
                    end else begin
                        shadowNxt = shadowShifted;
                        idxNxt    = digit_idx + IDX_W'(1);
                    end
                end else begin
                    dialNxt = dialStep;
                end
            end
            ST_LOCKOUT: begin
                if (timerDone) begin
                    stateNxt = ST_ENTRY;
                    failNxt  = '0;
                    idxNxt   = '0;
                    dialNxt  = '0;
                    errNxt   = 1'b0;
                end
            end
            default: stateNxt = ST_ENTRY;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ENTRY;
            cur_digit   <= '0;
            digit_idx   <= '0;
            fail_cnt    <= '0;
            code        <= DEFAULT_CODE;
            shadow      <= '0;
            errFlag     <= 1'b0;
            bad_code    <= 1'b0;
            unlocked    <= 1'b0;
            prog_active <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= stateNxt;
            cur_digit   <= dialNxt;
            digit_idx   <= idxNxt;
            fail_cnt    <= failNxt;
            code        <= codeNxt;
            shadow      <= shadowNxt;
            errFlag     <= errNxt;
            bad_code    <= badNxt;
            unlocked    <= (stateNxt == ST_UNLOCKED);
            prog_active <= (stateNxt == ST_PROG);
            alarm       <= (stateNxt == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_param_combo_lock.sv
// Self-checking bench for param_combo_lock (default parameters) with a
// queue-based behavioural model of the lock.
module tb_param_combo_lock;

    localparam int DIAL_MOD = 16;
    localparam int LEN      = 4;
    localparam int TRIES    = 3;
    localparam int LOCK_CYC = 16;
    localparam logic [15:0] DEF_CODE = 16'hFACE;

    localparam int M_ENTRY = 0, M_UNLOCKED = 1, M_PROG = 2, M_LOCKOUT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_enter = 1'b0, btn_prog = 1'b0;
    logic [3:0] cur_digit;
    logic [2:0] digit_idx;
    logic       unlocked, prog_active, alarm, bad_code;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    // Model state
    int mMode;
    int mDial;
    int mAttempt[$];
    int mShadow[$];
    int mCode[LEN];
    int mFails;
    int mLeft;
    bit mBad;

    param_combo_lock dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .btn_enter   (btn_enter),
        .btn_prog    (btn_prog),
        .cur_digit   (cur_digit),
        .digit_idx   (digit_idx),
        .unlocked    (unlocked),
        .prog_active (prog_active),
        .alarm       (alarm),
        .bad_code    (bad_code),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mMode = M_ENTRY;
        mDial = 0;
        mAttempt.delete();
        mShadow.delete();
        for (int i = 0; i < LEN; i++) mCode[i] = int'((DEF_CODE >> (4 * (LEN - 1 - i))) & 16'hF);
        mFails = 0;
        mLeft = 0;
        mBad = 1'b0;
    endfunction

    function automatic void modelMove(input bit inc, input bit dec);
        if (inc && !dec) mDial = (mDial + 1) % DIAL_MOD;
        if (dec && !inc) mDial = (mDial + DIAL_MOD - 1) % DIAL_MOD;
    endfunction

    // One clock of the lock rules, applied to the digit lists.
    function automatic void modelStep(input bit inc, input bit dec, input bit ent, input bit prg);
        bit match;
        mBad = 1'b0;
        case (mMode)
            M_ENTRY: begin
                if (ent) begin
                    mAttempt.push_back(mDial);
                    if (mAttempt.size() == LEN) begin
                        match = 1'b1;
                        for (int i = 0; i < LEN; i++) if (mAttempt[i] != mCode[i]) match = 1'b0;
                        mAttempt.delete();
                        if (match) begin
                            mMode = M_UNLOCKED;
                            mFails = 0;
                        end else begin
                            mBad = 1'b1;
                            mFails++;
                            if (mFails == TRIES) begin
                                mMode = M_LOCKOUT;
                                mLeft = LOCK_CYC;
                            end
                        end
                    end
                end else modelMove(inc, dec);
            end
            M_UNLOCKED: begin
                if (ent) begin
                    mMode = M_ENTRY;
                    mAttempt.delete();
                end else if (prg) begin
                    mMode = M_PROG;
                    mShadow.delete();
                end
            end
            M_PROG: begin
                if (prg) begin
                    mMode = M_UNLOCKED;
                    mShadow.delete();
                end else if (ent) begin
                    mShadow.push_back(mDial);
                    if (mShadow.size() == LEN) begin
                        for (int i = 0; i < LEN; i++) mCode[i] = mShadow[i];
                        mShadow.delete();
                        mMode = M_ENTRY;
                    end
                end else modelMove(inc, dec);
            end
            default: begin
                mLeft--;
                if (mLeft == 0) begin
                    mMode = M_ENTRY;
                    mFails = 0;
                    mDial = 0;
                    mAttempt.delete();
                end
            end
        endcase
    endfunction

    function automatic logic [12:0] expVec();
        int idx;
        idx = (mMode == M_ENTRY) ? mAttempt.size() : (mMode == M_PROG) ? mShadow.size() : 0;
        return {4'(mDial), 3'(idx), (mMode == M_UNLOCKED), (mMode == M_PROG),
                (mMode == M_LOCKOUT), mBad, 2'(mFails)};
    endfunction

    function automatic logic [12:0] obsVec();
        return {cur_digit, digit_idx, unlocked, prog_active, alarm, bad_code, fail_cnt};
    endfunction

    task automatic press(input bit inc, input bit dec, input bit ent, input bit prg);
        btn_inc = inc; btn_dec = dec; btn_enter = ent; btn_prog = prg;
        @(posedge clk); #1;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_enter = 1'b0; btn_prog = 1'b0;
        modelStep(inc, dec, ent, prg);
    endtask

    task automatic setDial(input int target);
        int n;
        n = (target - mDial + DIAL_MOD) % DIAL_MOD;
        repeat (n) press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enterCode(input logic [15:0] c);
        for (int i = 0; i < LEN; i++) begin
            setDial(int'(c[15 - 4 * i -: 4]));
            press(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_enter = 1'b0; btn_prog = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obsVec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obsVec(), 13'd0);
        end
        doReset();
        @(posedge clk); #1;
        checks++;
        if (obsVec() !== expVec()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obsVec(), expVec());
        end
    endtask

    task automatic test_unlock();
        doReset();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cur_digit !== 4'hF) begin
            errors++;
            $display("FAIL unlock_dec_wrap: got %h expected F", cur_digit);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({unlocked, digit_idx} !== {1'b0, 3'd3}) begin
            errors++;
            $display("FAIL unlock_three_digits: got %b/%0d expected 0/3", unlocked, digit_idx);
        end
        repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({unlocked, fail_cnt} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL unlock_face: got unlocked=%b fail=%0d expected 1/0", unlocked, fail_cnt);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obsVec() !== expVec()) begin
            errors++;
            $display("FAIL unlock_inc_ignored: got %h expected %h", obsVec(), expVec());
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({unlocked, digit_idx} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL relock: got %b/%0d expected 0/0", unlocked, digit_idx);
        end
    endtask

    task automatic test_lockout();
        int alarmCycles;
        doReset();
        for (int t = 0; t < TRIES; t++) begin
            enterCode(16'hCACA);
            checks++;
            if ({bad_code, fail_cnt} !== {1'b1, 2'(t + 1)}) begin
                errors++;
                $display("FAIL lockout_bad%0d: got bad=%b fail=%0d expected 1/%0d", t, bad_code, fail_cnt, t + 1);
            end
        end
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL lockout_alarm_on: got %b expected 1", alarm);
        end
        alarmCycles = 1;
        for (int k = 0; k < 100 && alarm === 1'b1; k++) begin
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL lockout_cycle%0d: got %h expected %h", k, obsVec(), expVec());
            end
            if (alarm === 1'b1) alarmCycles++;
        end
        checks++;
        if (alarmCycles != LOCK_CYC) begin
            errors++;
            $display("FAIL lockout_length: got %0d expected %0d", alarmCycles, LOCK_CYC);
        end
        checks++;
        if (obsVec() !== 13'd0) begin
            errors++;
            $display("FAIL lockout_exit: got %h expected %h", obsVec(), 13'd0);
        end
    endtask

    task automatic test_dial_edges();
        doReset();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cur_digit !== 4'h0) begin
            errors++;
            $display("FAIL dial_inc_wrap: got %h expected 0", cur_digit);
        end
        setDial(5);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cur_digit !== 4'h5) begin
            errors++;
            $display("FAIL dial_inc_dec: got %h expected 5", cur_digit);
        end
        setDial(15);
        press(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({cur_digit, digit_idx} !== {4'hF, 3'd1}) begin
            errors++;
            $display("FAIL dial_enter_inc: got %h/%0d expected F/1", cur_digit, digit_idx);
        end
        setDial(10);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        setDial(12);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        setDial(14);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({unlocked, bad_code} !== 2'b10) begin
            errors++;
            $display("FAIL dial_enter_priority_unlock: got %b%b expected 10", unlocked, bad_code);
        end
    endtask

    task automatic test_program();
        doReset();
        enterCode(DEF_CODE);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (prog_active !== 1'b1) begin
            errors++;
            $display("FAIL prog_enter: got %b expected 1", prog_active);
        end
        enterCode(16'h1234);
        checks++;
        if ({prog_active, unlocked} !== 2'b00) begin
            errors++;
            $display("FAIL prog_done: got %b%b expected 00", prog_active, unlocked);
        end
        enterCode(DEF_CODE);
        checks++;
        if (bad_code !== 1'b1) begin
            errors++;
            $display("FAIL prog_old_rejected: got %b expected 1", bad_code);
        end
        enterCode(16'h1234);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL prog_new_accepted: got %b expected 1", unlocked);
        end
    endtask

    task automatic test_prog_abort();
        doReset();
        enterCode(DEF_CODE);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        setDial(7);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        setDial(8);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({unlocked, prog_active} !== 2'b10) begin
            errors++;
            $display("FAIL abort_state: got %b%b expected 10", unlocked, prog_active);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        enterCode(DEF_CODE);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL abort_code_kept: got %b expected 1", unlocked);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        setDial(3);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        checks++;
        if ({digit_idx, cur_digit} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_attempt: got %0d/%h expected 0/0", digit_idx, cur_digit);
        end
        enterCode(DEF_CODE);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        enterCode(16'h1234);
        doReset();
        enterCode(DEF_CODE);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL reset_prog_lost: got %b expected 1", unlocked);
        end
    endtask

    task automatic test_random();
        logic [15:0] c;
        doReset();
        for (int n = 0; n < 1500; n++) begin
            if ((n % 150 == 149) && (mMode == M_ENTRY || mMode == M_PROG)) begin
                c = {4'(mCode[0]), 4'(mCode[1]), 4'(mCode[2]), 4'(mCode[3])};
                enterCode(c);
            end else begin
                press(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
            end
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL random_step%0d: got %h expected %h", n, obsVec(), expVec());
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_unlock();
        test_lockout();
        test_dial_edges();
        test_program();
        test_prog_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_combo_lock.md
PARAM_COMBO_LOCK -- requirements
Module: param_combo_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits in the code (2..8).
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit (hex dial).
REQ-003 SHALL have parameter MAX_TRIES, default 3, consecutive failed attempts before lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles.
REQ-005 SHALL have parameter DEFAULT_CODE, default 16'hFACE, CODE_LEN*DIGIT_W bits; digit 0 is the most significant digit.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port btn_inc  input  1  one-cycle pulse, dial +1.
REQ-009 SHALL have port btn_dec  input  1  one-cycle pulse, dial -1.
REQ-010 SHALL have port btn_enter  input  1  one-cycle pulse, commit dial digit.
REQ-011 SHALL have port btn_prog  input  1  one-cycle pulse, enter or abort program mode.
REQ-012 SHALL have port cur_digit  output  DIGIT_W  current dial value.
REQ-013 SHALL have port digit_idx  output  clog2(CODE_LEN+1)  count of digits committed in the current attempt.
REQ-014 SHALL have port unlocked  output  1  high in UNLOCKED.
REQ-015 SHALL have port prog_active  output  1  high in PROG.
REQ-016 SHALL have port alarm  output  1  high in LOCKOUT.
REQ-017 SHALL have port bad_code  output  1  one-cycle pulse on a failed attempt.
REQ-018 SHALL have port fail_cnt  output  clog2(MAX_TRIES+1)  consecutive failures.

Function
REQ-019 SHALL implement states ENTRY, UNLOCKED, PROG and LOCKOUT; all outputs SHALL be registered.
REQ-020 SHALL, in ENTRY and PROG, add 1 to cur_digit on inc and subtract 1 on dec, modulo 2^DIGIT_W (F+1=0, 0-1=F).
REQ-021 SHALL leave cur_digit unchanged when inc and dec are asserted in the same cycle.
REQ-022 SHALL give enter priority over inc/dec in the same cycle; the dial does not move that cycle.
REQ-023 SHALL retain cur_digit after an enter; it is not cleared between digits.
REQ-024 SHALL, on enter in ENTRY, compare cur_digit with code digit[digit_idx], OR any mismatch into a sticky error flag, and increment digit_idx.
REQ-025 SHALL evaluate the attempt on the enter that commits digit CODE_LEN.
REQ-026 SHALL, if no mismatch, enter UNLOCKED (unlocked=1 on the next cycle) and clear fail_cnt.
REQ-027 SHALL, on a mismatch, pulse bad_code for 1 cycle, increment fail_cnt, clear digit_idx and the error flag, and stay in ENTRY.
REQ-028 SHALL enter LOCKOUT when fail_cnt reaches MAX_TRIES.
REQ-029 SHALL, in LOCKOUT, ignore all buttons for LOCKOUT_CYCLES cycles, then enter ENTRY with fail_cnt=0, digit_idx=0 and cur_digit=0.
REQ-030 SHALL, in UNLOCKED, relock on enter (go to ENTRY, digit_idx=0) and go to PROG on btn_prog; inc/dec are ignored.
REQ-031 SHALL, in PROG, shift each entered digit into a shadow code register.
REQ-032 SHALL, on digit CODE_LEN in PROG, copy the shadow register to the active code and go to ENTRY (locked).
REQ-033 SHALL, on btn_prog during PROG, abort, leave the code unchanged and return to UNLOCKED.
REQ-034 SHALL ignore btn_prog in ENTRY and LOCKOUT.

Reset
REQ-035 SHALL, while rst_n=0, hold state=ENTRY, cur_digit=0, digit_idx=0, fail_cnt=0, code=DEFAULT_CODE, shadow=0, lockout counter=0, and all flag outputs at 0.
REQ-036 SHALL let reset asserted mid-attempt, mid-program or mid-lockout discard all progress; a programmed code is lost.

Structure
REQ-037 SHALL place the state enum and the DEFAULT_CODE default in package combo_lock_pkg.
REQ-038 SHALL implement the lockout down-counter as sub-module combo_lockout_timer (load, count, done).

Verification (defaults; L=dec, R=inc, C=enter)
REQ-039 SHALL cover: after reset, L, C (F); L x5, C (A); R x2, C (C); R x2, C (E) -> unlocked=1 one cycle after the last C, fail_cnt=0.
REQ-040 SHALL cover: three attempts of C,A,C,A -> bad_code pulses 3 times, fail_cnt 1, 2, then alarm=1 for exactly 16 cycles with presses ignored, then alarm=0, fail_cnt=0.
REQ-041 SHALL cover: dial at 0 plus dec -> F; F plus inc -> 0; inc+dec together -> unchanged; enter+inc together -> committed digit is the pre-inc value.
REQ-042 SHALL cover: unlock, prog, enter 1,2,3,4 -> prog_active=0 and locked; FACE -> bad_code; 1234 -> unlocked.
REQ-043 SHALL cover: prog, enter 2 digits, prog -> UNLOCKED, code still FACE.
REQ-044 SHALL cover: rst_n low after 2 digits, or after programming 1234 -> digit_idx=0, cur_digit=0, code FACE.
